// File: rtl/ahb_lite_master_bridge.sv
// Single-transfer AHB-Lite master: one NONSEQ SINGLE per accepted request, with
// lane-masked read data, error/timeout status and a busy/done handshake.
module ahb_lite_master_bridge #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 256
) (
    input  logic              AFT_CLK,
    input  logic              TRST,
    input  logic              ren,
    input  logic              wen,
    input  logic [ADDR_W-1:0] addr_aft,
    input  logic [DATA_W-1:0] wdata_aft,
    input  logic [3:0]        byte_en,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rdata,
    output logic              err,
    output logic              timeout,
    output logic [ADDR_W-1:0] HADDR,
    output logic [1:0]        HTRANS,
    output logic              HWRITE,
    output logic [2:0]        HSIZE,
    output logic [2:0]        HBURST,
    output logic [3:0]        HPROT,
    output logic              HMASTLOCK,
    output logic [DATA_W-1:0] HWDATA,
    input  logic [DATA_W-1:0] HRDATA,
    input  logic              HREADY,
    input  logic              HRESP
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR  = 3'd1,
        ST_DATA  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_RESP  = 3'd4
    } state_t;

    localparam logic [1:0]        TR_IDLE   = 2'b00;
    localparam logic [1:0]        TR_NONSEQ = 2'b10;
    localparam int                CNT_W     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam bit                TO_EN     = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
    localparam logic [ADDR_W-1:0] WORD_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};

    // Returns {legal, hsize[2:0], lane offset[1:0]} for a byte-enable pattern.
    function automatic logic [5:0] decode_be(input logic [3:0] be);
        logic [5:0] res;
        case (be)
            4'b1111: res = {1'b1, 3'b010, 2'b00};
            4'b0011: res = {1'b1, 3'b001, 2'b00};
            4'b1100: res = {1'b1, 3'b001, 2'b10};
            4'b0001: res = {1'b1, 3'b000, 2'b00};
            4'b0010: res = {1'b1, 3'b000, 2'b01};
            4'b0100: res = {1'b1, 3'b000, 2'b10};
            4'b1000: res = {1'b1, 3'b000, 2'b11};
            default: res = {1'b0, 3'b000, 2'b00};
        endcase
        return res;
    endfunction

    function automatic logic [DATA_W-1:0] lane_mask(input logic [3:0] be);
        logic [DATA_W-1:0] m;
        m = '0;
        for (int i = 0; i < 4; i++) begin
            m[8*i +: 8] = {8{be[i]}};
        end
        return m;
    endfunction

    state_t              state_r, state_s;
    logic [1:0]          htrans_r, htrans_s;
    logic [ADDR_W-1:0]   haddr_r, haddr_s;
    logic                hwrite_r, hwrite_s;
    logic [2:0]          hsize_r, hsize_s;
    logic [DATA_W-1:0]   hwdata_r, hwdata_s;
    logic [DATA_W-1:0]   wdata_lat_r, wdata_lat_s;
    logic [3:0]          be_lat_r, be_lat_s;
    logic                busy_r, busy_s;
    logic                done_r, done_s;
    logic                err_r, err_s;
    logic                timeout_r, timeout_s;
    logic [DATA_W-1:0]   rdata_r, rdata_s;
    logic [CNT_W-1:0]    wait_cnt_r, wait_cnt_s;
    logic [5:0]          dec_s;

    assign dec_s = decode_be(byte_en);

    // Next-state and next-output logic for the transfer FSM.
    always_comb begin
        state_s     = state_r;
        htrans_s    = htrans_r;
        haddr_s     = haddr_r;
        hwrite_s    = hwrite_r;
        hsize_s     = hsize_r;
        hwdata_s    = hwdata_r;
        wdata_lat_s = wdata_lat_r;
        be_lat_s    = be_lat_r;
        busy_s      = busy_r;
        done_s      = 1'b0;
        err_s       = 1'b0;
        timeout_s   = 1'b0;
        rdata_s     = rdata_r;
        wait_cnt_s  = wait_cnt_r;
        case (state_r)
            ST_IDLE: begin
                if ((ren || wen) && (!(ren && wen)) && dec_s[5]) begin
                    htrans_s    = TR_NONSEQ;
                    haddr_s     = (addr_aft & WORD_MASK) | {{(ADDR_W-2){1'b0}}, dec_s[1:0]};
                    hwrite_s    = wen;
                    hsize_s     = dec_s[4:2];
                    wdata_lat_s = wdata_aft;
                    be_lat_s    = byte_en;
                    busy_s      = 1'b1;
                    state_s     = ST_ADDR;
                end else if (ren || wen) begin
                    // Illegal request: answered locally, the bus never sees it.
                    done_s  = 1'b1;
                    err_s   = 1'b1;
                    state_s = ST_RESP;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ADDR: begin
                if (HREADY) begin
                    htrans_s   = TR_IDLE;
                    hwdata_s   = hwrite_r ? wdata_lat_r : '0;
                    wait_cnt_s = '0;
                    state_s    = ST_DATA;
                end else begin
                    state_s = ST_ADDR;
                end
            end
            ST_DATA: begin
                if (HREADY) begin
                    rdata_s  = hwrite_r ? '0 : (HRDATA & lane_mask(be_lat_r));
                    err_s    = HRESP;
                    done_s   = 1'b1;
                    busy_s   = 1'b0;
                    hwdata_s = '0;
                    state_s  = ST_RESP;
                end else if (TO_EN && (wait_cnt_r == CNT_LAST)) begin
                    // Report now, but the slave still owns the data phase until HREADY.
                    done_s    = 1'b1;
                    err_s     = 1'b1;
                    timeout_s = 1'b1;
                    state_s   = ST_DRAIN;
                end else begin
                    wait_cnt_s = wait_cnt_r + CNT_W'(1);
                end
            end
            ST_DRAIN: begin
                if (HREADY) begin
                    busy_s   = 1'b0;
                    hwdata_s = '0;
                    state_s  = ST_IDLE;
                end else begin
                    state_s = ST_DRAIN;
                end
            end
            ST_RESP: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s  = ST_IDLE;
                htrans_s = TR_IDLE;
                busy_s   = 1'b0;
            end
        endcase
    end

    // State and registered bus/handshake outputs.
    always_ff @(posedge AFT_CLK or negedge TRST) begin
        if (!TRST) begin
            state_r     <= ST_IDLE;
            htrans_r    <= TR_IDLE;
            haddr_r     <= '0;
            hwrite_r    <= 1'b0;
            hsize_r     <= 3'b000;
            hwdata_r    <= '0;
            wdata_lat_r <= '0;
            be_lat_r    <= 4'b0000;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
            timeout_r   <= 1'b0;
            rdata_r     <= '0;
            wait_cnt_r  <= '0;
        end else begin
            state_r     <= state_s;
            htrans_r    <= htrans_s;
            haddr_r     <= haddr_s;
            hwrite_r    <= hwrite_s;
            hsize_r     <= hsize_s;
            hwdata_r    <= hwdata_s;
            wdata_lat_r <= wdata_lat_s;
            be_lat_r    <= be_lat_s;
            busy_r      <= busy_s;
            done_r      <= done_s;
            err_r       <= err_s;
            timeout_r   <= timeout_s;
            rdata_r     <= rdata_s;
            wait_cnt_r  <= wait_cnt_s;
        end
    end

    assign busy      = busy_r;
    assign done      = done_r;
    assign err       = err_r;
    assign timeout   = timeout_r;
    assign rdata     = rdata_r;
    assign HADDR     = haddr_r;
    assign HTRANS    = htrans_r;
    assign HWRITE    = hwrite_r;
    assign HSIZE     = hsize_r;
    assign HWDATA    = hwdata_r;
    assign HBURST    = 3'b000;
    assign HPROT     = 4'b0011;
    assign HMASTLOCK = 1'b0;

endmodule

// File: tb/tb_ahb_lite_master_bridge.sv
// Directed bench for ahb_lite_master_bridge (TIMEOUT=4); inputs change and
// outputs are sampled on the falling edge.
module tb_ahb_lite_master_bridge;

    logic        AFT_CLK = 1'b0;
    logic        TRST;
    logic        ren, wen;
    logic [31:0] addr_aft, wdata_aft;
    logic [3:0]  byte_en;
    logic        busy, done, err, timeout;
    logic [31:0] rdata, HADDR, HWDATA, HRDATA;
    logic [1:0]  HTRANS;
    logic        HWRITE, HMASTLOCK, HREADY, HRESP;
    logic [2:0]  HSIZE, HBURST;
    logic [3:0]  HPROT;

    int tests_run = 0;
    int tests_failed = 0;

    ahb_lite_master_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
        .AFT_CLK(AFT_CLK), .TRST(TRST), .ren(ren), .wen(wen),
        .addr_aft(addr_aft), .wdata_aft(wdata_aft), .byte_en(byte_en),
        .busy(busy), .done(done), .rdata(rdata), .err(err), .timeout(timeout),
        .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
        .HBURST(HBURST), .HPROT(HPROT), .HMASTLOCK(HMASTLOCK), .HWDATA(HWDATA),
        .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
    );

    always #5 AFT_CLK = ~AFT_CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(negedge AFT_CLK);
    endtask

    task automatic idle_inputs();
        ren = 1'b0; wen = 1'b0; addr_aft = 32'h0; wdata_aft = 32'h0; byte_en = 4'b0000;
        HREADY = 1'b1; HRESP = 1'b0; HRDATA = 32'h0;
    endtask

    task automatic test_reset();
        idle_inputs();
        TRST = 1'b0;
        step(); step();
        tests_run++;
        if ({busy, done, err, timeout} !== 4'b0000) begin
            tests_failed++; $display("FAIL reset_status: got %b expected 0000", {busy, done, err, timeout});
        end
        tests_run++;
        if ({HTRANS, HWRITE, HSIZE} !== 6'b0) begin
            tests_failed++; $display("FAIL reset_ctrl: got %b expected 000000", {HTRANS, HWRITE, HSIZE});
        end
        tests_run++;
        if ({HADDR, HWDATA, rdata} !== 96'h0) begin
            tests_failed++; $display("FAIL reset_data: got %h %h %h expected zeros", HADDR, HWDATA, rdata);
        end
        tests_run++;
        if ({HBURST, HPROT, HMASTLOCK} !== 8'b000_0011_0) begin
            tests_failed++; $display("FAIL const_outputs: got %b expected 00000110", {HBURST, HPROT, HMASTLOCK});
        end
        TRST = 1'b1;
        step();
    endtask

    task automatic test_word_read();
        ren = 1'b1; addr_aft = 32'h2000_0010; byte_en = 4'b1111; HRDATA = 32'hDEAD_BEEF;
        step(); // cycle 1
        tests_run++;
        if ({HTRANS, HWRITE, HSIZE, busy} !== {2'b10, 1'b0, 3'b010, 1'b1}) begin
            tests_failed++; $display("FAIL wr_rd_addr_phase: got %b expected 1000101", {HTRANS, HWRITE, HSIZE, busy});
        end
        tests_run++;
        if (HADDR !== 32'h2000_0010) begin
            tests_failed++; $display("FAIL wr_rd_haddr: got %h expected 20000010", HADDR);
        end
        step(); // cycle 2
        tests_run++;
        if ({HTRANS, done} !== 3'b000) begin
            tests_failed++; $display("FAIL wr_rd_data_phase: got %b expected 000", {HTRANS, done});
        end
        step(); // cycle 3
        tests_run++;
        if ({done, err, timeout, busy} !== 4'b1000 || rdata !== 32'hDEAD_BEEF) begin
            tests_failed++; $display("FAIL wr_rd_done: got %b rdata %h expected 1000 rdata deadbeef", {done, err, timeout, busy}, rdata);
        end
        ren = 1'b0;
        step(); // cycle 4
        tests_run++;
        if (done !== 1'b0) begin
            tests_failed++; $display("FAIL wr_rd_done_pulse: got %b expected 0", done);
        end
    endtask

    task automatic test_byte_write();
        wen = 1'b1; addr_aft = 32'h0000_0100; byte_en = 4'b0100; wdata_aft = 32'h00AB_0000;
        step(); // cycle 1
        tests_run++;
        if (HADDR !== 32'h0000_0102 || {HTRANS, HWRITE, HSIZE} !== {2'b10, 1'b1, 3'b000}) begin
            tests_failed++; $display("FAIL bw_addr_phase: got %h %b expected 00000102 101000", HADDR, {HTRANS, HWRITE, HSIZE});
        end
        step(); // cycle 2
        tests_run++;
        if (HWDATA !== 32'h00AB_0000 || HTRANS !== 2'b00) begin
            tests_failed++; $display("FAIL bw_hwdata: got %h %b expected 00ab0000 00", HWDATA, HTRANS);
        end
        step(); // cycle 3
        tests_run++;
        if ({done, err, timeout} !== 3'b100) begin
            tests_failed++; $display("FAIL bw_done: got %b expected 100", {done, err, timeout});
        end
        wen = 1'b0;
        step();
    endtask

    task automatic test_half_read_wait();
        ren = 1'b1; addr_aft = 32'h0000_0203; byte_en = 4'b1100; HRDATA = 32'h1234_5678;
        step(); // cycle 1
        tests_run++;
        if (HADDR !== 32'h0000_0202 || HSIZE !== 3'b001) begin
            tests_failed++; $display("FAIL hr_addr: got %h %b expected 00000202 001", HADDR, HSIZE);
        end
        step(); // cycle 2
        HREADY = 1'b0;
        step(); step(); step(); // cycle 5
        HREADY = 1'b1;
        tests_run++;
        if ({done, busy} !== 2'b01) begin
            tests_failed++; $display("FAIL hr_wait_busy: got %b expected 01", {done, busy});
        end
        step(); // cycle 6
        tests_run++;
        if ({done, err, timeout} !== 3'b100 || rdata !== 32'h1234_0000) begin
            tests_failed++; $display("FAIL hr_done: got %b rdata %h expected 100 rdata 12340000", {done, err, timeout}, rdata);
        end
        ren = 1'b0;
        step();
    endtask

    task automatic test_write_error();
        wen = 1'b1; addr_aft = 32'h0000_0300; byte_en = 4'b1111; wdata_aft = 32'h1122_3344;
        step(); // cycle 1
        step(); // cycle 2
        HREADY = 1'b0; HRESP = 1'b1;
        tests_run++;
        if (HTRANS !== 2'b00) begin
            tests_failed++; $display("FAIL we_htrans_c2: got %b expected 00", HTRANS);
        end
        step(); // cycle 3
        tests_run++;
        if ({HTRANS, done} !== 3'b000) begin
            tests_failed++; $display("FAIL we_first_err_cycle: got %b expected 000", {HTRANS, done});
        end
        HREADY = 1'b1;
        step(); // cycle 4
        tests_run++;
        if ({done, err, timeout, HTRANS} !== 5'b11000) begin
            tests_failed++; $display("FAIL we_done: got %b expected 11000", {done, err, timeout, HTRANS});
        end
        HRESP = 1'b0; wen = 1'b0;
        step();
    endtask

    task automatic test_timeout();
        int extra_done;
        ren = 1'b1; addr_aft = 32'h0000_0400; byte_en = 4'b1111;
        step(); // cycle 1
        step(); // cycle 2
        HREADY = 1'b0;
        step(); step(); step(); // cycle 5
        tests_run++;
        if (done !== 1'b0) begin
            tests_failed++; $display("FAIL to_early: got done %b expected 0", done);
        end
        step(); // cycle 6
        tests_run++;
        if ({done, err, timeout, busy} !== 4'b1111) begin
            tests_failed++; $display("FAIL to_done: got %b expected 1111", {done, err, timeout, busy});
        end
        ren = 1'b0;
        extra_done = 0;
        for (int c = 7; c <= 12; c++) begin
            step();
            if (done) extra_done++;
        end
        tests_run++;
        if (busy !== 1'b1) begin
            tests_failed++; $display("FAIL to_busy_hold: got %b expected 1", busy);
        end
        HREADY = 1'b1;
        step(); // cycle 13
        if (done) extra_done++;
        tests_run++;
        if (busy !== 1'b0 || extra_done !== 0) begin
            tests_failed++; $display("FAIL to_drain: got busy %b extra_done %0d expected 0 0", busy, extra_done);
        end
        step();
    endtask

    task automatic test_illegal();
        ren = 1'b1; wen = 1'b1; byte_en = 4'b1111; addr_aft = 32'h0000_0500;
        step(); // cycle 1
        tests_run++;
        if ({done, err, busy, HTRANS} !== 5'b11000) begin
            tests_failed++; $display("FAIL ill_both: got %b expected 11000", {done, err, busy, HTRANS});
        end
        ren = 1'b0; wen = 1'b0;
        step(); step();
        ren = 1'b1; byte_en = 4'b0110;
        step(); // cycle 1
        tests_run++;
        if ({done, err, busy, HTRANS} !== 5'b11000) begin
            tests_failed++; $display("FAIL ill_be: got %b expected 11000", {done, err, busy, HTRANS});
        end
        ren = 1'b0;
        step();
        tests_run++;
        if ({done, busy, HTRANS} !== 4'b0000) begin
            tests_failed++; $display("FAIL ill_after: got %b expected 0000", {done, busy, HTRANS});
        end
        step();
    endtask

    task automatic test_back_to_back();
        wen = 1'b1; addr_aft = 32'h0000_0600; byte_en = 4'b0011; wdata_aft = 32'h0000_5A5A;
        step(); step(); step(); // cycle 3: done
        tests_run++;
        if ({done, err} !== 2'b10) begin
            tests_failed++; $display("FAIL b2b_first_done: got %b expected 10", {done, err});
        end
        wen = 1'b0; ren = 1'b1; addr_aft = 32'h0000_0700; byte_en = 4'b0001; HRDATA = 32'hCAFE_F00D;
        step(); // done+1
        tests_run++;
        if ({HTRANS, busy, done} !== 4'b0000) begin
            tests_failed++; $display("FAIL b2b_gap: got %b expected 0000", {HTRANS, busy, done});
        end
        step(); // done+2
        tests_run++;
        if (HTRANS !== 2'b10 || HADDR !== 32'h0000_0700 || HWRITE !== 1'b0) begin
            tests_failed++; $display("FAIL b2b_second_addr: got %b %h %b expected 10 00000700 0", HTRANS, HADDR, HWRITE);
        end
        step(); step();
        tests_run++;
        if (done !== 1'b1 || rdata !== 32'h0000_000D) begin
            tests_failed++; $display("FAIL b2b_second_done: got %b %h expected 1 0000000d", done, rdata);
        end
        ren = 1'b0;
        step();
    endtask

    task automatic test_trst_mid();
        int seen_done;
        ren = 1'b1; addr_aft = 32'h0000_0800; byte_en = 4'b1111;
        step(); step(); // cycle 2, DATA
        HREADY = 1'b0;
        #1 TRST = 1'b0;
        #1;
        tests_run++;
        if ({busy, done, err, timeout, HTRANS, HWRITE, HSIZE} !== 10'b0 || HADDR !== 32'h0 || HWDATA !== 32'h0) begin
            tests_failed++; $display("FAIL trst_mid: got %b %h %h expected all zero", {busy, done, err, timeout, HTRANS, HWRITE, HSIZE}, HADDR, HWDATA);
        end
        step();
        ren = 1'b0; HREADY = 1'b1; TRST = 1'b1;
        seen_done = 0;
        for (int c = 0; c < 5; c++) begin
            step();
            if (done || busy) seen_done++;
        end
        tests_run++;
        if (seen_done !== 0) begin
            tests_failed++; $display("FAIL trst_no_done: got %0d active cycles expected 0", seen_done);
        end
    endtask

    initial begin
        test_reset();
        test_word_read();
        test_byte_write();
        test_half_read_wait();
        test_write_error();
        test_timeout();
        test_illegal();
        test_back_to_back();
        test_trst_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
